// File: rtl/pds_pwr_seq.sv
// pds_pwr_seq: PoE power-up sequencer. Takes per-port turn-on requests from the
// power allocator and enables ports one at a time: a detection re-check window,
// then an inrush window with fault monitoring, then a guard gap. Turn-off,
// steady-on faults and global shutdown act immediately, outside the sequence.
// Optional build macro PDS_SEQ_PRIO_EN: adds a 2-bit per-port priority input
// and replaces round-robin selection with highest-priority / lowest-index.
module pds_pwr_seq #(
  parameter int NUM_PORTS  = 4,
  parameter int DET_CYC    = 8,
  parameter int INRUSH_CYC = 16,
  parameter int GAP_CYC    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_PORTS-1:0]         req_on,
  input  logic [NUM_PORTS-1:0]         req_off,
  input  logic [NUM_PORTS-1:0]         det_ok,
  input  logic [NUM_PORTS-1:0]         fault,
  input  logic                         ports_off,
  input  logic [NUM_PORTS-1:0]         fault_clr,
`ifdef PDS_SEQ_PRIO_EN
  input  logic [NUM_PORTS*2-1:0]       prio,
`endif
  output logic [NUM_PORTS-1:0]         port_en,
  output logic [NUM_PORTS-1:0]         fault_lat,
  output logic                         busy,
  output logic [$clog2(NUM_PORTS)-1:0] cur_port,
  output logic                         det_fail,
  output logic                         seq_done
);

  localparam int PW   = $clog2(NUM_PORTS);
  localparam int MAXA = (DET_CYC > INRUSH_CYC) ? DET_CYC : INRUSH_CYC;
  localparam int MAXW = (MAXA > GAP_CYC) ? MAXA : GAP_CYC;
  localparam int CW   = $clog2(MAXW) + 1;

  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] DET_LAST = CW'(DET_CYC - 1);
  localparam logic [CW-1:0] INR_LAST = CW'(INRUSH_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);

  typedef enum logic [1:0] {IDLE, DETECT, INRUSH, GUARD} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [PW-1:0]         cur_q, cur_d;
  logic [NUM_PORTS-1:0]  port_en_q, port_en_d;
  logic [NUM_PORTS-1:0]  fault_lat_q, fault_lat_d;
  logic                  det_fail_q, det_fail_d;
  logic                  seq_done_q, seq_done_d;

  logic [NUM_PORTS-1:0]  cand;
  logic                  sel_vld;
  logic [PW-1:0]         sel_idx;

  // Ports eligible to start a sequence; req_off outranks req_on.
  always_comb cand = req_on & ~req_off & ~port_en_q & ~fault_lat_q;

`ifdef PDS_SEQ_PRIO_EN
  logic [1:0] best;

  // Highest priority wins; strict '>' keeps the lowest index on ties.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    best    = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (cand[i] && (!sel_vld || prio[2*i +: 2] > best)) begin
        sel_vld = 1'b1;
        sel_idx = PW'(i);
        best    = prio[2*i +: 2];
      end
    end
  end
`else
  logic [PW-1:0] ptr_q, ptr_d;

  // Round-robin search starting at the pointer, ascending with wrap.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      idx = (32'(ptr_q) + k) % NUM_PORTS;
      if (!sel_vld && cand[idx]) begin
        sel_vld = 1'b1;
        sel_idx = PW'(idx);
      end
    end
    ptr_d = ptr_q;
    if (state_q == IDLE && sel_vld && !ports_off) begin
      ptr_d = (sel_idx == PW'(NUM_PORTS - 1)) ? '0 : sel_idx + PW'(1);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`endif

  // Sequencer next-state, counter and port-enable/fault-latch update.
  always_comb begin
    logic [NUM_PORTS-1:0] cur_oh;
    logic [NUM_PORTS-1:0] lat_set;
    logic [CW-1:0]        cnt_inc;
    logic                 abort;

    cur_oh          = '0;
    cur_oh[cur_q]   = 1'b1;
    lat_set         = '0;
    cnt_inc         = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    abort           = req_off[cur_q] || !req_on[cur_q];

    state_d    = state_q;
    cnt_d      = cnt_inc;
    cur_d      = cur_q;
    det_fail_d = 1'b0;
    seq_done_d = 1'b0;

    // Turn-off and steady-on faults act on every port; the port inside its
    // inrush window is excluded here because its fault is handled below.
    port_en_d = port_en_q & ~req_off
              & ~(fault & port_en_q & ~((state_q == INRUSH) ? cur_oh : '0));

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (sel_vld && !ports_off) begin
          state_d = DETECT;
          cur_d   = sel_idx;
        end
      end
      DETECT: begin
        if (abort) begin
          state_d = GUARD;
          cnt_d   = '0;
        end else if (!det_ok[cur_q]) begin
          det_fail_d = 1'b1;
          state_d    = GUARD;
          cnt_d      = '0;
        end else if (cnt_q == DET_LAST) begin
          port_en_d[cur_q] = 1'b1;
          state_d          = INRUSH;
          cnt_d            = '0;
        end
      end
      INRUSH: begin
        if (abort) begin
          port_en_d[cur_q] = 1'b0;
          state_d          = GUARD;
          cnt_d            = '0;
        end else if (fault[cur_q]) begin
          port_en_d[cur_q] = 1'b0;
          lat_set[cur_q]   = 1'b1;
          state_d          = GUARD;
          cnt_d            = '0;
        end else if (cnt_q == INR_LAST) begin
          seq_done_d = 1'b1;
          state_d    = GUARD;
          cnt_d      = '0;
        end
      end
      GUARD: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Global shutdown overrides everything decided above.
    if (ports_off) begin
      state_d    = IDLE;
      cnt_d      = '0;
      port_en_d  = '0;
      lat_set    = '0;
      det_fail_d = 1'b0;
      seq_done_d = 1'b0;
    end

    fault_lat_d = (fault_lat_q & ~fault_clr) | lat_set;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cur_q       <= '0;
      port_en_q   <= '0;
      fault_lat_q <= '0;
      det_fail_q  <= 1'b0;
      seq_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_q       <= cur_d;
      port_en_q   <= port_en_d;
      fault_lat_q <= fault_lat_d;
      det_fail_q  <= det_fail_d;
      seq_done_q  <= seq_done_d;
    end
  end

  assign port_en   = port_en_q;
  assign fault_lat = fault_lat_q;
  assign busy      = (state_q != IDLE);
  assign cur_port  = cur_q;
  assign det_fail  = det_fail_q;
  assign seq_done  = seq_done_q;

endmodule

// File: tb/tb_pds_pwr_seq.sv
// tb_pds_pwr_seq: directed self-checking bench for pds_pwr_seq (4/8/16/4).
// Cycle numbers below count rising edges after the stimulus is applied.
module tb_pds_pwr_seq;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req_on = '0, req_off = '0, det_ok = '1, fault = '0, fault_clr = '0;
  logic         ports_off = 1'b0;
`ifdef PDS_SEQ_PRIO_EN
  logic [2*N-1:0] prio = '0;
`endif
  logic [N-1:0] port_en, fault_lat;
  logic         busy, det_fail, seq_done;
  logic [1:0]   cur_port;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pds_pwr_seq #(
    .NUM_PORTS (N),
    .DET_CYC   (8),
    .INRUSH_CYC(16),
    .GAP_CYC   (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_on   (req_on),
    .req_off  (req_off),
    .det_ok   (det_ok),
    .fault    (fault),
    .ports_off(ports_off),
    .fault_clr(fault_clr),
`ifdef PDS_SEQ_PRIO_EN
    .prio     (prio),
`endif
    .port_en  (port_en),
    .fault_lat(fault_lat),
    .busy     (busy),
    .cur_port (cur_port),
    .det_fail (det_fail),
    .seq_done (seq_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_on = '0; req_off = '0; det_ok = '1; fault = '0; fault_clr = '0; ports_off = 1'b0;
`ifdef PDS_SEQ_PRIO_EN
    prio = '0;
`endif
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_on = '1;
    tick();
    tick();
    n_checks++;
    if ({port_en, fault_lat} !== 8'h00) $display("FAIL reset_en_lat: got %b/%b want 0000/0000", port_en, fault_lat);
    else n_pass++;
    n_checks++;
    if ({busy, cur_port, det_fail, seq_done} !== 5'b0) $display("FAIL reset_status: got busy=%b cur=%0d df=%b sd=%b want all 0", busy, cur_port, det_fail, seq_done);
    else n_pass++;
  endtask

  task automatic test_latency();
    int rise, sd, bf, nsd;
    rise = 0; sd = 0; bf = 0; nsd = 0;
    do_reset();
    req_on = 4'b0001;
    for (int e = 1; e <= 60; e++) begin
      tick();
      if (e == 1) begin
        n_checks++;
        if (busy !== 1'b1 || cur_port !== 2'd0) $display("FAIL lat_select: got busy=%b cur=%0d want 1/0", busy, cur_port);
        else n_pass++;
      end
      if (rise == 0 && port_en[0] === 1'b1) rise = e;
      if (seq_done === 1'b1) begin nsd++; if (sd == 0) sd = e; end
      if (sd != 0 && bf == 0 && busy === 1'b0) bf = e;
    end
    n_checks++;
    if (rise != 9) $display("FAIL lat_port_en: got cycle %0d want 9", rise);
    else n_pass++;
    n_checks++;
    if (sd != 25 || nsd != 1) $display("FAIL lat_seq_done: got cycle %0d count %0d want 25/1", sd, nsd);
    else n_pass++;
    n_checks++;
    if (bf != 29) $display("FAIL lat_busy_fall: got cycle %0d want 29", bf);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    int t[4];
    int ord[4];
    int n, multi;
    logic [N-1:0] prev, rise;
    n = 0; multi = 0; prev = '0;
    do_reset();
    req_on = '1;
    for (int e = 1; e <= 150; e++) begin
      tick();
      rise = port_en & ~prev;
      if ($countones(rise) > 1) multi++;
      for (int i = 0; i < N; i++) if (rise[i] && n < 4) begin ord[n] = i; t[n] = e; n++; end
      prev = port_en;
    end
    n_checks++;
    if (n != 4 || multi != 0) $display("FAIL rr_count: got %0d enables, %0d multi-rise cycles want 4/0", n, multi);
    else n_pass++;
    for (int k = 0; k < n; k++) begin
      n_checks++;
      if (ord[k] != k || t[k] != 9 + 29 * k) $display("FAIL rr_order%0d: got port %0d at %0d want port %0d at %0d", k, ord[k], t[k], k, 9 + 29 * k);
      else n_pass++;
    end
  endtask

  task automatic test_det_fail();
    int npulse, pe, rise, early;
    npulse = 0; pe = 0; rise = 0; early = 0;
    do_reset();
    req_on = 4'b0010;
    for (int e = 1; e <= 40; e++) begin
      det_ok = (e == 6) ? 4'b1101 : 4'b1111;
      tick();
      if (det_fail === 1'b1) begin npulse++; if (pe == 0) pe = e; end
      if (rise == 0 && port_en[1] === 1'b1) rise = e;
      if (e <= 18 && port_en !== 4'b0000) early++;
    end
    n_checks++;
    if (npulse != 1 || pe != 6) $display("FAIL det_fail_pulse: got %0d pulses first at %0d want 1 at 6", npulse, pe);
    else n_pass++;
    n_checks++;
    if (early != 0 || rise != 19) $display("FAIL det_retry: got %0d early-enable cycles, enable at %0d want 0/19", early, rise);
    else n_pass++;
  endtask

  task automatic test_inrush_fault();
    int bad, nsd, rise;
    bad = 0; nsd = 0; rise = 0;
    do_reset();
    req_on = 4'b0100;
    for (int e = 1; e <= 40; e++) begin
      fault = (e == 12) ? 4'b0100 : 4'b0000;
      tick();
      if (e == 11) begin
        n_checks++;
        if (port_en !== 4'b0100) $display("FAIL inrush_en: got %b want 0100", port_en);
        else n_pass++;
      end
      if (e == 12) begin
        n_checks++;
        if (port_en !== 4'b0000 || fault_lat !== 4'b0100) $display("FAIL inrush_fault: got en=%b lat=%b want 0000/0100", port_en, fault_lat);
        else n_pass++;
      end
      if (e > 12 && port_en !== 4'b0000) bad++;
      if (seq_done === 1'b1) nsd++;
    end
    n_checks++;
    if (bad != 0 || nsd != 0 || busy !== 1'b0 || fault_lat !== 4'b0100) $display("FAIL inrush_no_retry: got bad=%0d sd=%0d busy=%b lat=%b want 0/0/0/0100", bad, nsd, busy, fault_lat);
    else n_pass++;
    fault_clr = 4'b0100;
    tick();
    fault_clr = 4'b0000;
    n_checks++;
    if (fault_lat !== 4'b0000) $display("FAIL fault_clr: got %b want 0000", fault_lat);
    else n_pass++;
    for (int e = 2; e <= 30; e++) begin
      tick();
      if (rise == 0 && port_en[2] === 1'b1) rise = e;
    end
    n_checks++;
    if (rise != 10) $display("FAIL fault_clr_reseq: got cycle %0d want 10", rise);
    else n_pass++;
  endtask

  task automatic test_steady_fault();
    int rise;
    rise = 0;
    do_reset();
    req_on = 4'b0001;
    for (int e = 1; e <= 30; e++) tick();
    n_checks++;
    if (port_en !== 4'b0001 || busy !== 1'b0) $display("FAIL steady_on: got en=%b busy=%b want 0001/0", port_en, busy);
    else n_pass++;
    fault = 4'b0001;
    tick();
    fault = 4'b0000;
    n_checks++;
    if (port_en !== 4'b0000 || fault_lat !== 4'b0000) $display("FAIL steady_fault: got en=%b lat=%b want 0000/0000", port_en, fault_lat);
    else n_pass++;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (rise == 0 && port_en[0] === 1'b1) rise = e;
    end
    n_checks++;
    if (rise != 9) $display("FAIL steady_reseq: got cycle %0d want 9", rise);
    else n_pass++;
  endtask

  task automatic test_turn_off();
    int bad;
    bad = 0;
    do_reset();
    req_on = 4'b0011;
    for (int e = 1; e <= 45; e++) begin
      req_off = (e >= 34) ? 4'b0010 : 4'b0000;
      tick();
      if (e == 33) begin
        n_checks++;
        if (busy !== 1'b1 || cur_port !== 2'd1) $display("FAIL off_pre: got busy=%b cur=%0d want 1/1", busy, cur_port);
        else n_pass++;
      end
      if (e == 34) begin
        n_checks++;
        if (port_en !== 4'b0001 || busy !== 1'b1) $display("FAIL off_abort: got en=%b busy=%b want 0001/1", port_en, busy);
        else n_pass++;
      end
      if (e >= 34 && (det_fail === 1'b1 || seq_done === 1'b1 || port_en[1] === 1'b1)) bad++;
    end
    n_checks++;
    if (bad != 0 || busy !== 1'b0) $display("FAIL off_quiet: got bad=%0d busy=%b want 0/0", bad, busy);
    else n_pass++;
    req_off = 4'b0011;
    tick();
    n_checks++;
    if (port_en !== 4'b0000) $display("FAIL off_steady: got %b want 0000", port_en);
    else n_pass++;
    for (int e = 1; e <= 5; e++) tick();
    n_checks++;
    if (busy !== 1'b0) $display("FAIL off_priority: got busy=%b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_ports_off_and_async_reset();
    int t, rise;
    t = 0; rise = 0;
    do_reset();
    req_on = '1;
    for (int e = 1; e <= 150; e++) begin
      tick();
      if (port_en === 4'b1111) begin t = e; break; end
    end
    n_checks++;
    if (t != 96 || busy !== 1'b1) $display("FAIL all_enabled: got cycle %0d busy=%b want 96/1", t, busy);
    else n_pass++;
    ports_off = 1'b1;
    tick();
    ports_off = 1'b0;
    n_checks++;
    if (port_en !== 4'b0000 || busy !== 1'b0 || det_fail !== 1'b0 || seq_done !== 1'b0)
      $display("FAIL ports_off: got en=%b busy=%b df=%b sd=%b want 0000/0/0/0", port_en, busy, det_fail, seq_done);
    else n_pass++;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (port_en[0] === 1'b1) begin rise = e; break; end
    end
    n_checks++;
    if (rise != 9) $display("FAIL ports_off_reseq: got cycle %0d want 9", rise);
    else n_pass++;
    tick(); tick(); tick();
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({port_en, fault_lat, busy, cur_port, det_fail, seq_done} !== 13'b0)
      $display("FAIL async_reset: got en=%b lat=%b busy=%b cur=%0d df=%b sd=%b want all 0", port_en, fault_lat, busy, cur_port, det_fail, seq_done);
    else n_pass++;
  endtask

`ifdef PDS_SEQ_PRIO_EN
  task automatic test_prio();
    int ord[4];
    int exp_ord[4];
    int n;
    logic [N-1:0] prev, rise;
    n = 0; prev = '0;
    exp_ord[0] = 1; exp_ord[1] = 3; exp_ord[2] = 0; exp_ord[3] = 2;
    do_reset();
    prio   = {2'd3, 2'd0, 2'd3, 2'd1};
    req_on = '1;
    for (int e = 1; e <= 150; e++) begin
      tick();
      rise = port_en & ~prev;
      for (int i = 0; i < N; i++) if (rise[i] && n < 4) begin ord[n] = i; n++; end
      prev = port_en;
    end
    n_checks++;
    if (n != 4) $display("FAIL prio_count: got %0d want 4", n);
    else n_pass++;
    for (int k = 0; k < n; k++) begin
      n_checks++;
      if (ord[k] != exp_ord[k]) $display("FAIL prio_order%0d: got port %0d want %0d", k, ord[k], exp_ord[k]);
      else n_pass++;
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_round_robin();
    test_det_fail();
    test_inrush_fault();
    test_steady_fault();
    test_turn_off();
    test_ports_off_and_async_reset();
`ifdef PDS_SEQ_PRIO_EN
    test_prio();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
